// File: rtl/run_length_meter_if.sv
// ---------------------------------------------------------------------------
// +-------------------------------------------------------------------------+
// | Module  : run_length_meter_if                                           |
// | Purpose : Bundles the serial input stream and run-report outputs of     |
// |           run_length_meter.                                             |
// |   master : drives x_valid, x (and clr_ovf); observes the report.        |
// |   slave  : the meter itself.                                            |
// |   Signals: x_valid, x, run_len[CNT_W], run_valid, run_sat               |
// |            clr_ovf, ovf_flag  (only with RLM_OVF_FLAG_EN defined)       |
// | Rev     : 1.0  initial release                                          |
// +-------------------------------------------------------------------------+
// ---------------------------------------------------------------------------
`default_nettype none

interface run_length_meter_if #(
  parameter int CNT_W = 2
);
  logic             x_valid;
  logic             x;
  logic [CNT_W-1:0] run_len;
  logic             run_valid;
  logic             run_sat;
`ifdef RLM_OVF_FLAG_EN
  logic             clr_ovf;
  logic             ovf_flag;

  modport master (output x_valid, x, clr_ovf,
                  input  run_len, run_valid, run_sat, ovf_flag);
  modport slave  (input  x_valid, x, clr_ovf,
                  output run_len, run_valid, run_sat, ovf_flag);
`else
  modport master (output x_valid, x,
                  input  run_len, run_valid, run_sat);
  modport slave  (input  x_valid, x,
                  output run_len, run_valid, run_sat);
`endif
endinterface

`default_nettype wire

// File: rtl/run_length_meter.sv
// ---------------------------------------------------------------------------
// +-------------------------------------------------------------------------+
// | Module  : run_length_meter                                              |
// | Purpose : Measures runs of the POLARITY symbol on a qualified serial    |
// |           stream, each run bracketed by guard symbols (~POLARITY), and  |
// |           reports the completed run length as a saturating count.       |
// | Ports   : clk      - clock, rising edge                                 |
// |           rst      - synchronous active-high reset                      |
// |           bus      - run_length_meter_if.slave (x_valid, x, run_len,    |
// |                      run_valid, run_sat [, clr_ovf, ovf_flag])          |
// | Params  : CNT_W (2..8), POLARITY (0/1), MIN_RUN (1..2^CNT_W-1)          |
// | Macro   : RLM_OVF_FLAG_EN adds the sticky ovf_flag with clr_ovf.        |
// | Rev     : 1.0  initial release                                          |
// +-------------------------------------------------------------------------+
// ---------------------------------------------------------------------------
`default_nettype none

module run_length_meter #(
  parameter int CNT_W    = 2,
  parameter bit POLARITY = 1'b1,
  parameter int MIN_RUN  = 1
) (
  input  wire                     clk,
  input  wire                     rst,
  run_length_meter_if.slave       bus
);

  localparam logic [CNT_W-1:0] MAX_C     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MIN_RUN_C = CNT_W'(MIN_RUN);
  localparam logic [CNT_W-1:0] ONE_C     = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    COUNT = 2'd2,
    SAT   = 2'd3
  } state_t;

  state_t           state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [CNT_W-1:0] run_len_q,   run_len_d;
  logic             run_valid_q, run_valid_d;
  logic             run_sat_q,   run_sat_d;

  logic             is_p;
  logic [CNT_W-1:0] cnt_inc;

  assign is_p    = (bus.x == POLARITY);
  // cnt is strictly below MAX while in COUNT, so the increment cannot wrap.
  assign cnt_inc = cnt_q + ONE_C;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    run_len_d   = '0;
    run_valid_d = 1'b0;
    run_sat_d   = 1'b0;

    if (bus.x_valid) begin
      unique case (state_q)
        IDLE: begin
          // A run without a leading guard is never measured.
          if (!is_p) state_d = ARMED;
        end
        ARMED: begin
          if (is_p) begin
            state_d = COUNT;
            cnt_d   = ONE_C;
          end
        end
        COUNT: begin
          if (is_p) begin
            cnt_d = cnt_inc;
            if (cnt_inc == MAX_C) state_d = SAT;
          end else begin
            if (cnt_q >= MIN_RUN_C) begin
              run_valid_d = 1'b1;
              run_len_d   = cnt_q;
            end
            // Terminating guard doubles as the next run's leading guard.
            state_d = ARMED;
            cnt_d   = '0;
          end
        end
        SAT: begin
          if (!is_p) begin
            run_valid_d = 1'b1;
            run_len_d   = cnt_q;
            run_sat_d   = 1'b1;
            state_d     = ARMED;
            cnt_d       = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      run_len_q   <= '0;
      run_valid_q <= 1'b0;
      run_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      run_len_q   <= run_len_d;
      run_valid_q <= run_valid_d;
      run_sat_q   <= run_sat_d;
    end
  end

  assign bus.run_len   = run_len_q;
  assign bus.run_valid = run_valid_q;
  assign bus.run_sat   = run_sat_q;

`ifdef RLM_OVF_FLAG_EN
  logic ovf_flag_q, ovf_flag_d;

  // Set takes priority over a simultaneous clear.
  always_comb begin
    ovf_flag_d = ovf_flag_q;
    if (bus.clr_ovf) ovf_flag_d = 1'b0;
    if (run_sat_d)   ovf_flag_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_flag_q <= 1'b0;
    else     ovf_flag_q <= ovf_flag_d;
  end

  assign bus.ovf_flag = ovf_flag_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_run_length_meter.sv
// ---------------------------------------------------------------------------
// +-------------------------------------------------------------------------+
// | Module  : tb_run_length_meter                                           |
// | Purpose : Self-checking bench for run_length_meter. Two instances share |
// |           one input stream: u0 with default parameters and u1 with      |
// |           CNT_W=4, POLARITY=0, MIN_RUN=3. A run-length reference model  |
// |           with unbounded integer lengths predicts every output.         |
// | Rev     : 1.0  initial release                                          |
// +-------------------------------------------------------------------------+
// ---------------------------------------------------------------------------
`default_nettype none

module tb_run_length_meter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  run_length_meter_if #(.CNT_W(2)) if0 ();
  run_length_meter_if #(.CNT_W(4)) if1 ();

  run_length_meter #(.CNT_W(2), .POLARITY(1'b1), .MIN_RUN(1)) u0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  run_length_meter #(.CNT_W(4), .POLARITY(1'b0), .MIN_RUN(3)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Reference model: per instance, whether a leading guard has been seen
  // and how many P symbols have been seen since it.
  int pol  [2] = '{1, 0};
  int maxv [2] = '{3, 15};
  int minr [2] = '{1, 3};
  bit seen [2];
  int len  [2];
  bit ev   [2];
  int el   [2];
  bit es   [2];
  bit eovf [2];

  task automatic model_step(input int i, input bit r, input bit v, input bit xb, input bit c);
    ev[i] = 1'b0; el[i] = 0; es[i] = 1'b0;
    if (r) begin
      seen[i] = 1'b0; len[i] = 0; eovf[i] = 1'b0;
    end else begin
      if (v) begin
        if (int'(xb) == pol[i]) begin
          if (seen[i]) len[i]++;
        end else begin
          if (seen[i] && len[i] > 0) begin
            if (len[i] >= maxv[i]) begin
              ev[i] = 1'b1; el[i] = maxv[i]; es[i] = 1'b1;
            end else if (len[i] >= minr[i]) begin
              ev[i] = 1'b1; el[i] = len[i];
            end
          end
          seen[i] = 1'b1;
          len[i]  = 0;
        end
      end
      if (c)     eovf[i] = 1'b0;
      if (es[i]) eovf[i] = 1'b1;
    end
  endtask

  // One clock: drive inputs, advance the model, check both instances.
  task automatic step(input bit r, input bit v, input bit xb, input bit c);
    rst = r;
    if0.x_valid = v; if0.x = xb;
    if1.x_valid = v; if1.x = xb;
`ifdef RLM_OVF_FLAG_EN
    if0.clr_ovf = c; if1.clr_ovf = c;
`endif
    model_step(0, r, v, xb, c);
    model_step(1, r, v, xb, c);
    @(posedge clk);
    #1;
    chk("u0.run_valid", 32'(if0.run_valid), 32'(ev[0]));
    chk("u0.run_len",   32'(if0.run_len),   32'(el[0]));
    chk("u0.run_sat",   32'(if0.run_sat),   32'(es[0]));
    chk("u1.run_valid", 32'(if1.run_valid), 32'(ev[1]));
    chk("u1.run_len",   32'(if1.run_len),   32'(el[1]));
    chk("u1.run_sat",   32'(if1.run_sat),   32'(es[1]));
`ifdef RLM_OVF_FLAG_EN
    chk("u0.ovf_flag",  32'(if0.ovf_flag),  32'(eovf[0]));
    chk("u1.ovf_flag",  32'(if1.ovf_flag),  32'(eovf[1]));
`endif
  endtask

  // '0'/'1' valid bits, 'g' gap cycle (x_valid=0, x=0), 'r' reset, 'c' clr_ovf with x_valid=0.
  task automatic play(input string s);
    for (int k = 0; k < s.len(); k++) begin
      case (s[k])
        "0":     step(1'b0, 1'b1, 1'b0, 1'b0);
        "1":     step(1'b0, 1'b1, 1'b1, 1'b0);
        "g":     step(1'b0, 1'b0, 1'b0, 1'b0);
        "r":     step(1'b1, 1'b1, 1'b0, 1'b0);
        "c":     step(1'b0, 1'b0, 1'b0, 1'b1);
        default: step(1'b0, 1'b0, 1'b0, 1'b0);
      endcase
    end
  endtask

  initial begin
    rst = 1'b1;
    if0.x_valid = 1'b0; if0.x = 1'b0;
    if1.x_valid = 1'b0; if1.x = 1'b0;
`ifdef RLM_OVF_FLAG_EN
    if0.clr_ovf = 1'b0; if1.clr_ovf = 1'b0;
`endif

    // Reset state, then the directed scenarios.
    play("rr");
    play("010gg");
    play("r0111110gg");
    play("cgg");
    play("r11011010gg");
    play("r100100001gg");
    play("r01ggg10gg");
    play("r011r10ggg");
    // Terminating guard coinciding with reset: reset wins.
    play("r011r");
    play("gg");

    // Randomised runs of either symbol with random qualification gaps,
    // occasional resets and clears.
    for (int n = 0; n < 400; n++) begin
      bit sym;
      int rl;
      sym = 1'($urandom_range(0, 1));
      rl  = $urandom_range(1, 20);
      for (int k = 0; k < rl; k++) begin
        bit v, r, c;
        v = ($urandom_range(0, 9) < 8);
        r = ($urandom_range(0, 299) == 0);
        c = ($urandom_range(0, 19) == 0);
        step(r, v, v ? sym : 1'($urandom_range(0, 1)), c);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
